// File: rtl/demux5_hold.sv
// demux5_hold: 1-to-5 write distributor with per-destination holding
// registers and a drain sequencer that hands valid entries to a single
// consumer in index order over a valid/ready handshake.
module demux5_hold #(
    parameter int DATA_W   = 32,
    parameter int NUM_DEST = 5,
    parameter int SEL_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [SEL_W-1:0]    selector,
    input  logic [DATA_W-1:0]   data_in,
    output logic                wr_ack,
    output logic [DATA_W-1:0]   data_0,
    output logic [DATA_W-1:0]   data_1,
    output logic [DATA_W-1:0]   data_2,
    output logic [DATA_W-1:0]   data_3,
    output logic [DATA_W-1:0]   data_4,
    output logic [NUM_DEST-1:0] dest_valid,
    input  logic                drain_start,
    output logic                drain_busy,
    output logic                drain_valid,
    input  logic                drain_ready,
    output logic [DATA_W-1:0]   drain_data,
    output logic [SEL_W-1:0]    drain_idx,
    output logic                drain_done
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PRESENT, S_DONE} state_t;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_DEST - 1);

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    idx_q, idx_d;
    // Set when the presented entry was rewritten after its snapshot was
    // taken; the handshake must then leave its valid flag alone.
    logic                pend_q, pend_d;
    logic [DATA_W-1:0]   drain_data_q, drain_data_d;
    logic [SEL_W-1:0]    drain_idx_q, drain_idx_d;
    logic                wr_ack_q, wr_ack_d;

    logic [DATA_W-1:0]   data_q [NUM_DEST];
    logic [DATA_W-1:0]   data_d [NUM_DEST];
    logic                valid_q [NUM_DEST];
    logic                valid_d [NUM_DEST];

    logic [SEL_W-1:0]    wr_sel;
    logic [NUM_DEST-1:0] wr_hit;
    logic [NUM_DEST-1:0] clr_hit;
    logic                handshake;
    logic                wr_hit_cur;

    // Out-of-range selectors fold onto destination 0.
    always_comb begin
        wr_sel     = (selector < SEL_W'(NUM_DEST)) ? selector : '0;
        handshake  = (state_q == S_PRESENT) && drain_ready;
        wr_hit_cur = wr_en && (wr_sel == idx_q);
        wr_ack_d   = wr_en;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEST; gi++) begin : g_dest
            assign wr_hit[gi]  = wr_en && (wr_sel == SEL_W'(gi));
            assign clr_hit[gi] = handshake && !pend_q && (idx_q == SEL_W'(gi));
            // A write always beats a drain clear on the same entry.
            assign data_d[gi]  = wr_hit[gi] ? data_in : data_q[gi];
            assign valid_d[gi] = wr_hit[gi] | (valid_q[gi] & ~clr_hit[gi]);
            assign dest_valid[gi] = valid_q[gi];

            // Holding register and valid flag for one destination.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    data_q[gi]  <= '0;
                    valid_q[gi] <= 1'b0;
                end else begin
                    data_q[gi]  <= data_d[gi];
                    valid_q[gi] <= valid_d[gi];
                end
            end
        end
    endgenerate

    assign data_0 = data_q[0];
    assign data_1 = data_q[1];
    assign data_2 = data_q[2];
    assign data_3 = data_q[3];
    assign data_4 = data_q[4];

    // Drain FSM state, scan index, snapshot and write acknowledge registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            drain_data_q <= '0;
            drain_idx_q  <= '0;
            wr_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            drain_data_q <= drain_data_d;
            drain_idx_q  <= drain_idx_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    // Next-state logic: walk indices, stop on valid entries, wait for ready.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        drain_data_d = drain_data_q;
        drain_idx_d  = drain_idx_q;
        case (state_q)
            S_IDLE: begin
                if (drain_start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (valid_q[idx_q]) begin
                    state_d      = S_PRESENT;
                    drain_data_d = data_q[idx_q];
                    drain_idx_d  = idx_q;
                    pend_d       = wr_hit_cur;
                end else if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_PRESENT: begin
                pend_d = pend_q | wr_hit_cur;
                if (drain_ready) begin
                    pend_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SCAN;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from the FSM state and registered snapshot.
    always_comb begin
        drain_busy  = (state_q != S_IDLE);
        drain_valid = (state_q == S_PRESENT);
        drain_done  = (state_q == S_DONE);
        drain_data  = drain_data_q;
        drain_idx   = drain_idx_q;
        wr_ack      = wr_ack_q;
    end

endmodule

// File: tb/tb_demux5_hold.sv
// Directed testbench for demux5_hold: writes, drain ordering, backpressure,
// empty drain timing and asynchronous reset in the middle of a drain.
module tb_demux5_hold;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  selector;
    logic [31:0] data_in;
    logic        wr_ack;
    logic [31:0] data_0, data_1, data_2, data_3, data_4;
    logic [4:0]  dest_valid;
    logic        drain_start;
    logic        drain_busy;
    logic        drain_valid;
    logic        drain_ready;
    logic [31:0] drain_data;
    logic [2:0]  drain_idx;
    logic        drain_done;

    int passed = 0;
    int total  = 0;

    demux5_hold dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .selector    (selector),
        .data_in     (data_in),
        .wr_ack      (wr_ack),
        .data_0      (data_0),
        .data_1      (data_1),
        .data_2      (data_2),
        .data_3      (data_3),
        .data_4      (data_4),
        .dest_valid  (dest_valid),
        .drain_start (drain_start),
        .drain_busy  (drain_busy),
        .drain_valid (drain_valid),
        .drain_ready (drain_ready),
        .drain_data  (drain_data),
        .drain_idx   (drain_idx),
        .drain_done  (drain_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    // Advance to the next falling edge; the rising edge in between samples inputs.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] d);
        wr_en    = 1'b1;
        selector = sel;
        data_in  = d;
        tick();
        wr_en = 1'b0;
        check("wr_ack_pulse", {31'd0, wr_ack}, 32'd1);
        tick();
        check("wr_ack_drop", {31'd0, wr_ack}, 32'd0);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (drain_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [2:0]  out_idx [8];
        logic [31:0] out_dat [8];
        int          n_out;
        int          done_cnt;
        int          busy_cnt;
        int          done_pos;
        bit          valid_seen;
        bit          found;
        bit          seen;

        reset       = 1'b1;
        wr_en       = 1'b0;
        selector    = '0;
        data_in     = '0;
        drain_start = 1'b0;
        drain_ready = 1'b0;
        repeat (2) tick();

        // Reset state
        check("rst_dest_valid", {27'd0, dest_valid}, 32'd0);
        check("rst_data_0", data_0, 32'd0);
        check("rst_wr_ack", {31'd0, wr_ack}, 32'd0);
        check("rst_busy", {31'd0, drain_busy}, 32'd0);
        check("rst_drain_valid", {31'd0, drain_valid}, 32'd0);
        reset = 1'b0;
        tick();

        // Basic writes
        wr(3'd0, 32'h11111111);
        wr(3'd2, 32'h22222222);
        wr(3'd4, 32'h44444444);
        check("data_0", data_0, 32'h11111111);
        check("data_2", data_2, 32'h22222222);
        check("data_4", data_4, 32'h44444444);
        check("data_1_untouched", data_1, 32'd0);
        check("dest_valid_10101", {27'd0, dest_valid}, 32'h15);

        // Drain with ready high; a drain_start while busy must be ignored
        drain_ready = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        n_out    = 0;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (drain_valid && n_out < 8) begin
                out_idx[n_out] = drain_idx;
                out_dat[n_out] = drain_data;
                n_out++;
            end
            if (drain_done) done_cnt++;
            drain_start = (i == 3);
            tick();
        end
        drain_start = 1'b0;
        check("drain_count", n_out, 32'd3);
        if (n_out == 3) begin
            check("drain0_idx", {29'd0, out_idx[0]}, 32'd0);
            check("drain0_data", out_dat[0], 32'h11111111);
            check("drain1_idx", {29'd0, out_idx[1]}, 32'd2);
            check("drain1_data", out_dat[1], 32'h22222222);
            check("drain2_idx", {29'd0, out_idx[2]}, 32'd4);
            check("drain2_data", out_dat[2], 32'h44444444);
        end
        check("drain_done_pulses", done_cnt, 32'd1);
        check("drain_dest_valid_0", {27'd0, dest_valid}, 32'd0);
        check("drain_busy_end", {31'd0, drain_busy}, 32'd0);

        // Out-of-range selector lands on destination 0
        wr(3'd6, 32'hDEADBEEF);
        check("oor_data_0", data_0, 32'hDEADBEEF);
        check("oor_dest_valid", {27'd0, dest_valid}, 32'h01);
        check("oor_data_2_kept", data_2, 32'h22222222);

        // Backpressure on idx2 with a same-index rewrite during the stall
        wr(3'd2, 32'h22222222);
        drain_ready = 1'b1;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (drain_valid && drain_idx == 3'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        drain_ready = 1'b0;
        check("bp_found_idx2", {31'd0, found}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("bp_valid_held", {31'd0, drain_valid}, 32'd1);
            check("bp_data_stable", drain_data, 32'h22222222);
            check("bp_idx_stable", {29'd0, drain_idx}, 32'd2);
            check("bp_no_clear", {31'd0, dest_valid[2]}, 32'd1);
            if (k == 0) begin
                wr_en    = 1'b1;
                selector = 3'd2;
                data_in  = 32'h99999999;
            end
            tick();
            wr_en = 1'b0;
        end
        check("bp_data_2_new", data_2, 32'h99999999);
        check("bp_snapshot_kept", drain_data, 32'h22222222);
        drain_ready = 1'b1;
        tick();
        check("bp_after_hs_valid", {31'd0, drain_valid}, 32'd0);
        check("bp_after_hs_dv", {27'd0, dest_valid}, 32'h04);
        wait_done(seen);
        check("bp_done_seen", {31'd0, seen}, 32'd1);
        tick();

        // Clear the leftover entry so the bank is empty
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        wait_done(seen);
        check("clr_done_seen", {31'd0, seen}, 32'd1);
        tick();
        check("clr_dest_valid", {27'd0, dest_valid}, 32'd0);

        // Empty drain timing: busy after E0..E5, done after E5
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        busy_cnt   = 0;
        done_pos   = -1;
        valid_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (drain_busy) busy_cnt++;
            if (drain_done && done_pos < 0) done_pos = i;
            if (drain_valid) valid_seen = 1'b1;
            tick();
        end
        check("empty_busy_cycles", busy_cnt, 32'd6);
        check("empty_done_pos", done_pos, 32'd5);
        check("empty_no_valid", {31'd0, valid_seen}, 32'd0);

        // Asynchronous reset while an entry is presented
        wr(3'd1, 32'h12345678);
        drain_ready = 1'b0;
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (drain_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("ar_present_found", {31'd0, found}, 32'd1);
        check("ar_present_idx", {29'd0, drain_idx}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("ar_drain_valid", {31'd0, drain_valid}, 32'd0);
        check("ar_busy", {31'd0, drain_busy}, 32'd0);
        check("ar_dest_valid", {27'd0, dest_valid}, 32'd0);
        check("ar_data_1", data_1, 32'd0);
        check("ar_drain_data", drain_data, 32'd0);
        check("ar_drain_idx", {29'd0, drain_idx}, 32'd0);
        tick();
        reset       = 1'b0;
        drain_ready = 1'b1;
        tick();
        drain_start = 1'b1;
        tick();
        drain_start = 1'b0;
        valid_seen = 1'b0;
        done_pos   = -1;
        for (int i = 0; i < 8; i++) begin
            if (drain_valid) valid_seen = 1'b1;
            if (drain_done && done_pos < 0) done_pos = i;
            tick();
        end
        check("ar_empty_no_valid", {31'd0, valid_seen}, 32'd0);
        check("ar_empty_done_pos", done_pos, 32'd5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/demux5_hold.md
Name: demux5_hold

Overview:
- 1-to-5 write distributor with per-destination holding registers; the inverse of the 5-way source select used on the datapath.
- One 32-bit word is steered by a 3-bit selector into one of five registered destinations. Each destination has a valid flag.
- A drain sequencer emits the valid entries in index order over a valid/ready handshake.
- Sits between a single-source producer (ALU/memory result) and consumers that take results one at a time.

Parameters:
DATA_W, 32, width of data path and every holding register
NUM_DEST, 5, number of destinations (fixed at 5; selector decode assumes it)
SEL_W, 3, selector width

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
wr_en  input  1  write strobe, sampled on rising edge
selector  input  SEL_W  destination index for write
data_in  input  DATA_W  write data
wr_ack  output  1  registered one-cycle pulse, cycle after an accepted write
data_0..data_4  output  DATA_W each  holding registers, directly visible
dest_valid  output  NUM_DEST  per-destination valid flags
drain_start  input  1  request to drain all valid entries
drain_busy  output  1  high whenever drain FSM not IDLE
drain_valid  output  1  drain_data/drain_idx presented
drain_ready  input  1  consumer accepts presented entry
drain_data  output  DATA_W  registered snapshot of entry being drained
drain_idx  output  SEL_W  index of entry being drained
drain_done  output  1  one-cycle pulse at end of drain pass

Behaviour:
- Reset (async, any state, mid-drain included):
  - data_0..4=0, dest_valid=0, wr_ack=0.
  - drain_valid=0, drain_data=0, drain_idx=0, drain_busy=0, drain_done=0.
  - FSM=IDLE.
- Write:
  - On an edge with wr_en=1, data_sel <= data_in and dest_valid[sel] <= 1. wr_ack=1 for the following cycle only.
  - Writes are always accepted, in any FSM state.
  - selector 5..7: write goes to destination 0 (data_0, dest_valid[0]); wr_ack still pulses.
  - Overwriting a valid entry is legal; last write wins.
- Drain FSM states: IDLE, SCAN, PRESENT, DONE. Internal idx register, 0..4.
  - IDLE: drain_start=1 at an edge -> SCAN, idx=0. drain_start in any other state is ignored (not queued).
  - SCAN: one cycle per index.
    - If dest_valid[idx]=1: next edge -> PRESENT, latch drain_data=data_idx and drain_idx=idx, drain_valid=1.
    - Else if idx=4 -> DONE.
    - Else idx+1, stay in SCAN.
  - PRESENT: drain_valid held and drain_data stable until drain_valid&drain_ready at an edge.
    - At that edge: clear dest_valid[idx] and drop drain_valid.
    - Then idx=4 -> DONE, else idx+1 -> SCAN.
  - DONE: drain_done=1 for exactly one cycle -> IDLE.
  - drain_busy=1 in SCAN, PRESENT, DONE.
- Timing:
  - Empty bank: drain_start sampled at edge E0; SCAN for idx 0..4 after E0..E4; DONE after E5; IDLE after E6.
  - Each found entry adds one PRESENT cycle plus any ready stall.
- Simultaneous write and drain clear on the same index at one edge: write wins. data updates, dest_valid stays 1, drain_data snapshot not altered.
- Write to an entry while it is PRESENTed: data_k updates, drain_data keeps the snapshot. After the handshake dest_valid[k] remains 1 (write priority).
- Write to an index already passed in the current pass: stays valid, not drained until the next pass.
- Write to an index not yet scanned: picked up in the current pass.
- drain_ready while drain_valid=0 has no effect.

Test Plan:
- Reset then writes: sel=0 data 0x11111111, sel=2 0x22222222, sel=4 0x44444444 -> data_0/2/4 hold values, dest_valid=5'b10101, wr_ack pulses once per write.
- Out-of-range: wr_en with sel=6, data 0xDEADBEEF -> data_0=0xDEADBEEF, dest_valid[0]=1, other regs unchanged.
- Drain with ready tied high after the first test:
  - Outputs: (idx0,0x11111111), (idx2,0x22222222), (idx4,0x44444444) in order.
  - dest_valid ends 0; drain_done one pulse; drain_start while busy ignored.
- Backpressure: drain_ready low 3 cycles in PRESENT for idx2 -> drain_data/idx stable, no clear until ready. Same-index write 0x99999999 during the stall -> drain_data stays 0x22222222, dest_valid[2]=1 after handshake.
- Empty drain: dest_valid=0, drain_start -> drain_valid never high, drain_done pulses the 6th cycle after start edge (after E5), drain_busy high 6 cycles.
- Async reset mid-PRESENT: reset asserted between edges -> all outputs 0 immediately. After release, drain_start gives an empty drain.
